// File: rtl/led_pkg.sv
// led_pkg
// Shared types and constants for the LED chaser controller.
//   state_t          : controller state (IDLE, RUN, PAUSED)
//   DIR_LEFT/RIGHT   : values of the dir level input
//   MODE_WRAP/BOUNCE : values of the mode level input
//   DEFAULT_TICK_DIV : base prescaler terminal count for a 50 MHz board clock
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    localparam logic DIR_LEFT    = 1'b0;
    localparam logic DIR_RIGHT   = 1'b1;

    localparam logic MODE_WRAP   = 1'b0;
    localparam logic MODE_BOUNCE = 1'b1;

    localparam int unsigned DEFAULT_TICK_DIV = 50_000_000;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Free-running cycle counter that paces timed LED advances.
// Ports:
//   CLK, RST  : clock and asynchronous active-high reset
//   en        : count this cycle (controller is running and not being paused)
//   clr       : restart the count from 0 (start or clr pulse)
//   speed     : terminal count is TICK_DIV >> speed
//   tick_now  : high in the cycle whose edge performs the advance
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       tick_now
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      term_m1;
    logic             at_term;

    // Compare with >= rather than == so that raising the speed while the
    // count is already past the new terminal value fires on the next edge
    // instead of running on until the counter overflows.
    always_comb begin
        term_m1  = (32'(TICK_DIV) >> speed) - 32'd1;
        at_term  = (32'(cnt_q) >= term_m1);
        tick_now = en && at_term;
    end

    // Next count: restart has priority, otherwise count while enabled and
    // roll back to zero on the advancing edge.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_term ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_chaser_ctrl.sv
// led_chaser_ctrl
// Run-time controller for the one-hot LED chaser.
// Ports:
//   CLK, RST      : clock and asynchronous active-high reset
//   start/stop    : pulses to run and pause
//   clr           : pulse back to IDLE with the LED at position 0
//   step          : pulse for a single manual advance when not running
//   dir, mode     : direction (0 = toward MSB) and wrap(0)/bounce(1) levels
//   speed         : step period is TICK_DIV >> speed cycles
//   led           : one-hot LED pattern
//   tick          : pulse with every timed advance
//   wrap          : pulse on wrap-around or bounce reversal
//   running       : high in RUN
module led_chaser_ctrl
    import led_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
    input  logic             step,
    input  logic             dir,
    input  logic             mode,
    input  logic [1:0]       speed,
    output logic [WIDTH-1:0] led,
    output logic             tick,
    output logic             wrap,
    output logic             running
);

    localparam logic [WIDTH-1:0] LED_LSB = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LED_MSB = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             bdir_q, bdir_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    logic             presc_en;
    logic             presc_clr;
    logic             tick_now;

    logic [WIDTH-1:0] adv_led;
    logic             adv_bdir;
    logic             adv_wrap;
    logic             move_right;
    logic             led_onehot;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .CLK      (CLK),
        .RST      (RST),
        .en       (presc_en),
        .clr      (presc_clr),
        .speed    (speed),
        .tick_now (tick_now)
    );

    // Candidate next position for one advance, used by both timed and
    // stepped moves. Bounce follows the stored bdir; wrap follows the live
    // dir level. A corrupted (non-one-hot) pattern recovers to position 0.
    always_comb begin
        adv_led    = led_q;
        adv_bdir   = bdir_q;
        adv_wrap   = 1'b0;
        move_right = (mode == MODE_BOUNCE) ? bdir_q : dir;
        led_onehot = (led_q != '0) && ((led_q & (led_q - LED_LSB)) == '0);

        if (!led_onehot) begin
            adv_led = LED_LSB;
        end else if (move_right == DIR_LEFT) begin
            if (led_q[WIDTH-1]) begin
                adv_wrap = 1'b1;
                if (mode == MODE_BOUNCE) begin
                    adv_led  = LED_MSB >> 1;
                    adv_bdir = DIR_RIGHT;
                end else begin
                    adv_led = LED_LSB;
                end
            end else begin
                adv_led = led_q << 1;
            end
        end else begin
            if (led_q[0]) begin
                adv_wrap = 1'b1;
                if (mode == MODE_BOUNCE) begin
                    adv_led  = LED_LSB << 1;
                    adv_bdir = DIR_LEFT;
                end else begin
                    adv_led = LED_MSB;
                end
            end else begin
                adv_led = led_q >> 1;
            end
        end
    end

    // Control sequencing with priority clr > stop > start > step. A stop
    // pulse outside RUN does nothing but still blocks a same-cycle start.
    // The prescaler only counts in RUN cycles that are not being paused.
    always_comb begin
        state_d   = state_q;
        led_d     = led_q;
        bdir_d    = bdir_q;
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        presc_en  = 1'b0;
        presc_clr = 1'b0;

        if (clr) begin
            state_d   = ST_IDLE;
            led_d     = LED_LSB;
            bdir_d    = 1'b0;
            presc_clr = 1'b1;
        end else if (stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSED;
            end
        end else if (start && (state_q != ST_RUN)) begin
            state_d   = ST_RUN;
            presc_clr = 1'b1;
            if (state_q == ST_IDLE) begin
                bdir_d = dir;
            end
        end else if (state_q == ST_RUN) begin
            presc_en = 1'b1;
            if (tick_now) begin
                led_d  = adv_led;
                bdir_d = adv_bdir;
                wrap_d = adv_wrap;
                tick_d = 1'b1;
            end
        end else if (step) begin
            led_d  = adv_led;
            bdir_d = adv_bdir;
            wrap_d = adv_wrap;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            led_q   <= LED_LSB;
            bdir_q  <= 1'b0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            bdir_q  <= bdir_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign led     = led_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;
    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_led_chaser_ctrl.sv
// tb_led_chaser_ctrl
// Lock-step bench for led_chaser_ctrl (WIDTH=8, TICK_DIV=16). A position /
// counter model of the controller is advanced on every clock edge and all
// outputs are compared on the following falling edge. Directed sequences
// walk the main scenarios, then a randomized phase mixes pulses and levels.
module tb_led_chaser_ctrl;

    localparam int WIDTH    = 8;
    localparam int TICK_DIV = 16;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             clr = 1'b0;
    logic             step = 1'b0;
    logic             dir = 1'b0;
    logic             mode = 1'b0;
    logic [1:0]       speed = 2'd0;
    logic [WIDTH-1:0] led;
    logic             tick;
    logic             wrap;
    logic             running;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: LED position as an integer, bounce heading, cycle count
    int m_state;
    int m_pos;
    int m_cnt;
    bit m_bdir;
    bit m_tick;
    bit m_wrap;

    led_chaser_ctrl #(
        .WIDTH    (WIDTH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .stop    (stop),
        .clr     (clr),
        .step    (step),
        .dir     (dir),
        .mode    (mode),
        .speed   (speed),
        .led     (led),
        .tick    (tick),
        .wrap    (wrap),
        .running (running)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_pos   = 0;
        m_cnt   = 0;
        m_bdir  = 1'b0;
        m_tick  = 1'b0;
        m_wrap  = 1'b0;
    endtask

    // One position move following the wrap / bounce rules
    task automatic model_move();
        if (mode == 1'b0) begin
            if (dir == 1'b0) begin
                m_pos  = (m_pos + 1) % WIDTH;
                m_wrap = (m_pos == 0);
            end else begin
                m_pos  = (m_pos + WIDTH - 1) % WIDTH;
                m_wrap = (m_pos == WIDTH - 1);
            end
        end else if (m_bdir == 1'b0) begin
            if (m_pos == WIDTH - 1) begin
                m_bdir = 1'b1;
                m_pos  = WIDTH - 2;
                m_wrap = 1'b1;
            end else begin
                m_pos = m_pos + 1;
            end
        end else begin
            if (m_pos == 0) begin
                m_bdir = 1'b0;
                m_pos  = 1;
                m_wrap = 1'b1;
            end else begin
                m_pos = m_pos - 1;
            end
        end
    endtask

    // Model behaviour for one rising edge given the current inputs
    task automatic model_clock();
        int term;
        m_tick = 1'b0;
        m_wrap = 1'b0;
        if (clr) begin
            m_state = M_IDLE;
            m_pos   = 0;
            m_cnt   = 0;
            m_bdir  = 1'b0;
        end else if (stop) begin
            if (m_state == M_RUN) m_state = M_PAUSED;
        end else if (start && m_state != M_RUN) begin
            if (m_state == M_IDLE) m_bdir = dir;
            m_state = M_RUN;
            m_cnt   = 0;
        end else if (m_state == M_RUN) begin
            term = TICK_DIV >> speed;
            if (m_cnt >= term - 1) begin
                m_cnt  = 0;
                m_tick = 1'b1;
                model_move();
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else if (step) begin
            model_move();
        end
    endtask

    task automatic compare_all();
        logic [WIDTH-1:0] exp_led;
        exp_led = 8'd1 << m_pos;
        checkOutput("led", 32'(led), 32'(exp_led));
        checkOutput("tick", 32'(tick), 32'(m_tick));
        checkOutput("wrap", 32'(wrap), 32'(m_wrap));
        checkOutput("running", 32'(running), 32'(m_state == M_RUN));
    endtask

    // Drive one cycle of pulses (called at a falling edge), advance the
    // model on the rising edge and compare on the next falling edge.
    task automatic applyStimulus(input bit p_start, input bit p_stop, input bit p_clr, input bit p_step);
        start = p_start;
        stop  = p_stop;
        clr   = p_clr;
        step  = p_step;
        @(posedge CLK);
        model_clock();
        @(negedge CLK);
        start = 1'b0;
        stop  = 1'b0;
        clr   = 1'b0;
        step  = 1'b0;
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
    endtask

    task automatic run_to_pos(input int pos);
        for (int i = 0; i < 400 && m_pos != pos; i++) applyStimulus(0, 0, 0, 0);
    endtask

    initial begin
        int nt;
        int nw;
        int lat;
        int r;

        // Reset and a long idle stretch
        @(negedge CLK);
        RST = 1'b1;
        model_reset();
        repeat (3) @(negedge CLK);
        checkOutput("rst_led", 32'(led), 32'h01);
        checkOutput("rst_running", 32'(running), 32'h0);
        checkOutput("rst_tick", 32'(tick), 32'h0);
        checkOutput("rst_wrap", 32'(wrap), 32'h0);
        RST = 1'b0;
        idle_cycles(100);

        // Wrap mode to the left at speed 0: 8 advances in 128 cycles
        mode = 1'b0; dir = 1'b0; speed = 2'd0;
        applyStimulus(1, 0, 0, 0);
        nt = 0;
        for (int i = 0; i < 128; i++) begin
            applyStimulus(0, 0, 0, 0);
            if (tick) nt++;
        end
        checkOutput("tick_count", 32'(nt), 32'd8);
        checkOutput("wrap_to_lsb_led", 32'(led), 32'h01);
        checkOutput("wrap_to_lsb_flag", 32'(wrap), 32'h1);

        // Reverse direction: 01 rotates to 80
        dir = 1'b1;
        idle_cycles(16);
        checkOutput("wrap_to_msb_led", 32'(led), 32'h80);
        checkOutput("wrap_to_msb_flag", 32'(wrap), 32'h1);

        // Speed 2 gives a 4-cycle period
        speed = 2'd2;
        idle_cycles(24);

        // Asynchronous reset between edges while running
        #2 RST = 1'b1;
        #1;
        checkOutput("async_rst_led", 32'(led), 32'h01);
        checkOutput("async_rst_running", 32'(running), 32'h0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;

        // Speed raised 0 -> 3 with the count at 10
        dir = 1'b0; speed = 2'd0;
        applyStimulus(1, 0, 0, 0);
        idle_cycles(10);
        speed = 2'd3;
        applyStimulus(0, 0, 0, 0);
        checkOutput("speed_jump_tick", 32'(tick), 32'h1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("speed3_gap", 32'(tick), 32'h0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("speed3_period", 32'(tick), 32'h1);
        idle_cycles(20);

        // Bounce from IDLE heading left: 16 advances, two reversals
        applyStimulus(0, 0, 1, 0);
        mode = 1'b1; dir = 1'b0; speed = 2'd0;
        applyStimulus(1, 0, 0, 0);
        nw = 0;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(0, 0, 0, 0);
            if (wrap) nw++;
        end
        checkOutput("bounce_wraps", 32'(nw), 32'd2);
        checkOutput("bounce_end_led", 32'(led), 32'h04);

        // Pause at 04, then three manual steps
        applyStimulus(0, 0, 1, 0);
        mode = 1'b0; dir = 1'b0;
        applyStimulus(1, 0, 0, 0);
        run_to_pos(2);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
        checkOutput("steps_led", 32'(led), 32'h20);
        checkOutput("steps_tick", 32'(tick), 32'h0);
        checkOutput("steps_running", 32'(running), 32'h0);

        // Start and stop together keep it paused
        applyStimulus(1, 1, 0, 0);
        checkOutput("start_stop_running", 32'(running), 32'h0);

        // Resume: first timed advance 16 cycles later
        applyStimulus(1, 0, 0, 0);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            applyStimulus(0, 0, 0, 0);
            if (tick) begin
                lat = i;
                break;
            end
        end
        checkOutput("resume_latency", 32'(lat), 32'd16);

        // Clear at 10 while running
        run_to_pos(4);
        applyStimulus(0, 0, 1, 0);
        checkOutput("clr_led", 32'(led), 32'h01);
        checkOutput("clr_tick", 32'(tick), 32'h0);
        checkOutput("clr_running", 32'(running), 32'h0);

        // Step pulses during RUN are ignored
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
        checkOutput("step_in_run_led", 32'(led), 32'h01);

        // Randomized mix of pulses and level changes
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) speed = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 99);
            if (r < 2)       applyStimulus(0, 0, 1, 0);
            else if (r < 5)  applyStimulus(0, 1, 0, 0);
            else if (r < 9)  applyStimulus(1, 0, 0, 0);
            else if (r < 14) applyStimulus(0, 0, 0, 1);
            else if (r < 15) applyStimulus(1, 1, 0, 0);
            else             applyStimulus(0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/led_chaser_ctrl.md
Name: led_chaser_ctrl

Overview:
- Run-time controller for the one-hot LED chaser on the board's LED bank.
- Owns the tick prescaler, run/pause sequencing, direction, wrap/bounce mode, speed selection and single-step.
- Drives the LED vector directly; user-facing control inputs arrive as already-debounced single-cycle pulses or levels from the button/switch front end.

Parameters:
- WIDTH, 8, number of LEDs / one-hot bits (>= 2).
- TICK_DIV, 50000000, base prescaler terminal count in CLK cycles at speed=0 (>= 16).

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset (see Behaviour).
- start  in  1  pulse: enter/resume RUN.
- stop  in  1  pulse: pause (LED holds).
- clr  in  1  pulse: return to IDLE, LED to position 0.
- step  in  1  pulse: advance one position; honoured only when not in RUN.
- dir  in  1  level: 0 = toward MSB (left), 1 = toward LSB (right).
- mode  in  1  level: 0 = wrap-around rotate, 1 = bounce.
- speed  in  2  level: step period = TICK_DIV >> speed (x1, x2, x4, x8 faster).
- led  out  WIDTH  one-hot LED pattern.
- tick  out  1  one-cycle pulse on every timed advance.
- wrap  out  1  one-cycle pulse on wrap-around or bounce reversal (timed or stepped).
- running  out  1  high in RUN state.

Behaviour:
- Reset: RST, asynchronous, active-high; clock CLK.
  - led=1, running=0, tick=0, wrap=0, state=IDLE, prescaler cnt=0, bounce direction flag bdir=0.
  - RST mid-run takes effect immediately, without waiting for a clock edge.
- States:
  - IDLE: reset/clr default.
  - RUN.
  - PAUSED.
- Control priority per cycle: clr > stop > start > step.
  - clr (any state): to IDLE; led=1, cnt=0, bdir=0; tick/wrap not asserted.
  - stop in RUN: to PAUSED; led and cnt hold. stop elsewhere: no effect.
  - start in IDLE or PAUSED: to RUN; cnt cleared to 0.
    - From IDLE only, bdir is loaded from dir.
    - start in RUN: no effect (no prescaler restart).
  - start and stop in the same cycle: stop wins; a RUN block stays/goes PAUSED; IDLE stays IDLE.
  - step in IDLE/PAUSED: led advances one position on that edge; wrap asserts if the advance wraps or reverses; tick stays 0; state unchanged. step in RUN is ignored.
- Prescaler (RUN only):
  - TERM = TICK_DIV >> speed; cnt width = clog2(TICK_DIV).
  - Each cycle, if cnt >= TERM-1: cnt<=0, led advances, tick=1 on the following cycle (registered alongside the new led). Otherwise cnt<=cnt+1.
  - Timed-advance period is exactly TERM cycles; the first advance comes TERM cycles after the start edge.
  - Speed raised mid-count with cnt already >= new TERM-1: advance on the next edge, no overflow.
- Advance rule, mode=0 (wrap):
  - Rotate in direction dir, sampled at each advance.
  - MSB->LSB when dir=0, LSB->MSB when dir=1; wrap=1 on that advance.
- Advance rule, mode=1 (bounce):
  - Move in direction bdir.
  - At MSB with bdir=0: bdir<=1, led moves to MSB-1, wrap=1.
  - At LSB with bdir=1: bdir<=0, led moves to bit1, wrap=1.
  - dir is ignored while bouncing except on the load from IDLE.
- Mode switched mid-run: applies at the next advance. Switching into bounce takes the current bdir.
- led is always exactly one-hot. If it is ever found non-one-hot, the next advance or step loads 1.
- tick and wrap are never asserted for more than one cycle per advance.

Decomposition:
- Shared package led_pkg:
  - state enum (IDLE, RUN, PAUSED).
  - direction constants DIR_LEFT/DIR_RIGHT.
  - mode constants MODE_WRAP/MODE_BOUNCE.
  - default TICK_DIV.
- One sub-module, tick_prescaler:
  - Inputs: en, clr, speed. Output: tick_now.
  - Holds cnt and the >= TERM-1 compare.
- Top holds the FSM, the one-hot shifter/bounce logic and the output registers.

Test Plan (TICK_DIV=16, WIDTH=8):
- RST pulse, idle 100 cycles -> led=8'h01, running=0, tick=0, wrap=0 throughout. RST asserted mid-run between edges -> led=8'h01 and running=0 immediately.
- start, mode=0, dir=0, speed=0 -> tick every 16 cycles; led 01,02,04..80,01; wrap only on 80->01. dir=1 -> 01->80 with wrap.
- speed=2 -> period 4 cycles. Switch speed 0->3 when cnt=10 -> advance on the next edge, then period 2.
- mode=1 from IDLE with dir=0 -> 01..80,40,20..01,02. wrap on 80->40 and on 01->02 only.
- stop, then step x3 from led=04 -> led=20, tick=0, running=0. start and stop in the same cycle -> stays PAUSED. start -> first tick 16 cycles later.
- clr during RUN at led=10 -> IDLE, led=01, no tick. step while RUN -> led unchanged.
